// File: rtl/muldiv_unit_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit.
package muldiv_unit_pkg;

  // Operation codes presented on oper by the decoder.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Controller state encodings.
  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_CALC = 2'd1;
  localparam logic [1:0] MD_ST_FIX  = 2'd2;

  // True for the opcodes that run the iterative datapath.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the opcodes that treat operands as two's complement.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for the divide opcodes.
  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: acc = {partial product upper half, remaining multiplier bits};
//   add the multiplicand into the upper half when acc[0] is 1, then shift right.
// Divide: acc = {partial remainder, remaining dividend bits / quotient bits};
//   shift left, trial-subtract the divisor, keep the difference on no-borrow.
//   The new quotient bit is returned separately; acc_o carries a 0 in its LSB.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             no_borrow;

  // Compute both step flavours and select by mode.
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh    = acc_i[2*WIDTH-1:WIDTH-1];
    no_borrow = (rem_sh >= {1'b0, opnd_i});
    // When no_borrow holds the difference is below the divisor, so WIDTH bits suffice.
    trial     = rem_sh[WIDTH-1:0] - opnd_i;
    q_bit_o   = 1'b0;
    acc_o     = {mul_sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      q_bit_o = no_borrow;
      acc_o   = {(no_borrow ? trial : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Handshake: start is sampled only in IDLE. An accepted MULT/MULTU/DIV/DIVU
// raises busy from the next cycle until the result lands; done pulses for
// exactly one cycle when hi/lo take the result. MTHI/MTLO write in one edge
// without busy or done. start during busy is ignored.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               div_q, div_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sa_n, sb_n;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (div_q),
    .acc_o    (step_acc),
    .q_bit_o  (step_q)
  );

  // Sign correction of the unsigned magnitude result.
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Operand magnitudes and sign bits for an incoming request.
  always_comb begin
    sa_n  = md_is_signed(oper) & a[WIDTH-1];
    sb_n  = md_is_signed(oper) & b[WIDTH-1];
    a_mag = sa_n ? -a : a;
    b_mag = sb_n ? -b : b;
  end

  // Next-state logic: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_orig_d = a_orig_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div_d    = div_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      MD_ST_IDLE: begin
        if (start) begin
          if (oper == MD_MTHI) begin
            hi_d = a;
          end else if (oper == MD_MTLO) begin
            lo_d = a;
          end else if (md_is_arith(oper)) begin
            sa_d     = sa_n;
            sb_d     = sb_n;
            div_d    = md_is_div(oper);
            div0_d   = (b == '0);
            a_orig_d = a;
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
            opnd_d   = md_is_div(oper) ? b_mag : a_mag;
            acc_d    = md_is_div(oper) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = MD_ST_CALC;
          end
        end
      end
      MD_ST_CALC: begin
        acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = MD_ST_FIX;
        end
      end
      MD_ST_FIX: begin
        if (div_q) begin
          if (div0_q) begin
            lo_d = '1;
            hi_d = a_orig_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = MD_ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = MD_ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_orig_q <= a_orig_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div_q    <= div_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, handshake, sign rules, corner cases.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  oper;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .oper        (oper),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Reference result {hi, lo} for the arithmetic opcodes.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    case (op)
      MD_MULT:  return sx * sy;
      MD_MULTU: return {32'b0, x} * {32'b0, y};
      MD_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Drive one arithmetic op, optionally poke start while busy, and score the result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] want,
                        input int inject_at, input logic [2:0] inject_op);
    int cycles;
    logic busy_gap;
    logic [63:0] e;
    exp_q.push_back(want);
    @(negedge clk);
    start = 1'b1; oper = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, ".busy_rise"}, 32'(busy), 32'd1);
    cycles = 0;
    busy_gap = 1'b0;
    while (cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (cycles == inject_at) begin
        start = 1'b1; oper = inject_op; a = 32'd3; b = 32'd3;
      end
      if (done) break;
      if (!busy) busy_gap = 1'b1;
    end
    start = 1'b0;
    chk({name, ".latency"}, 32'(cycles), 32'd33);
    chk({name, ".busy_steady"}, 32'(busy_gap), 32'd0);
    chk({name, ".busy_fall"}, 32'(busy), 32'd0);
    e = exp_q.pop_front();
    chk({name, ".hi"}, hi, e[63:32]);
    chk({name, ".lo"}, lo, e[31:0]);
    @(posedge clk); #1;
    chk({name, ".done_pulse"}, 32'(done), 32'd0);
    chk({name, ".hold_hi"}, hi, e[63:32]);
    chk({name, ".hold_lo"}, lo, e[31:0]);
  endtask

  // Single-edge move into HI or LO.
  task automatic run_mt(input string name, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] want_hi, input logic [31:0] want_lo);
    @(negedge clk);
    start = 1'b1; oper = op; a = av;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, ".hi"}, hi, want_hi);
    chk({name, ".lo"}, lo, want_lo);
    chk({name, ".busy"}, 32'(busy), 32'd0);
    chk({name, ".done"}, 32'(done), 32'd0);
    chk({name, ".state"}, 32'(dbg_state), 32'(MD_ST_IDLE));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; start = 1'b0; oper = 3'd0; a = '0; b = '0;
    #1;
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.state", 32'(dbg_state), 32'(MD_ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Multiply vectors.
    run_op("mult_7x6",     MD_MULT,  32'd7,          32'd6,          64'h0000_0000_0000_002A, 0, MD_MULT);
    run_op("mult_m1x1",    MD_MULT,  32'hFFFF_FFFF,  32'd1,          64'hFFFF_FFFF_FFFF_FFFF, 0, MD_MULT);
    run_op("multu_m1x1",   MD_MULTU, 32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, 0, MD_MULT);
    run_op("multu_max",    MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0, MD_MULT);
    run_op("mult_m3x5",    MD_MULT,  32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 0, MD_MULT);
    run_op("mult_min_sq",  MD_MULT,  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 0, MD_MULT);
    run_op("multu_2p32",   MD_MULTU, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 0, MD_MULT);

    // Divide vectors.
    run_op("div_m7_2",     MD_DIV,   32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 0, MD_MULT);
    run_op("div_m7_m2",    MD_DIV,   32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFF_FFFF_0000_0003, 0, MD_MULT);
    run_op("div_7_m2",     MD_DIV,   32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 0, MD_MULT);
    run_op("divu_100_7",   MD_DIVU,  32'd100,        32'd7,          64'h0000_0002_0000_000E, 0, MD_MULT);
    run_op("divu_by0",     MD_DIVU,  32'd100,        32'd0,          64'h0000_0064_FFFF_FFFF, 0, MD_MULT);
    run_op("div_by0_neg",  MD_DIV,   32'hFFFF_FFF9,  32'd0,          64'hFFFF_FFF9_FFFF_FFFF, 0, MD_MULT);
    run_op("div_ovf",      MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 0, MD_MULT);

    // Moves in IDLE, then requests presented while busy.
    run_mt("mthi", MD_MTHI, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000);
    run_mt("mtlo", MD_MTLO, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
    run_op("div_inj_mult", MD_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 5, MD_MULT);
    run_op("div_inj_mthi", MD_DIV,  32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 5, MD_MTHI);
    run_op("mult_inj_mtlo", MD_MULT, 32'd9, 32'd11, 64'h0000_0000_0000_0063, 20, MD_MTLO);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    start = 1'b1; oper = MD_MULT; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.hi", hi, 32'd0);
    chk("midrst.lo", lo, 32'd0);
    chk("midrst.state", 32'(dbg_state), 32'(MD_ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mult_2x2_after_rst", MD_MULT, 32'd2, 32'd2, 64'h0000_0000_0000_0004, 0, MD_MULT);

    // Randomised operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 0, MD_MULT);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $finish;
  end

endmodule
